multi_score: RTL and testbench
==============================

MULTI_SCORE -- requirements
Module: multi_score

Interface
REQ-001 Parameter N_PLAYERS, default 2, SHALL set the player count, legal range 2..4.
REQ-002 Parameter DICE_W, default 4, SHALL set the die value width per player.
REQ-003 Parameter SCORE_W, default 4, SHALL set the score width per player.
REQ-004 Parameter WIN_SCORE, default 5, SHALL set the score that ends a game, legal range 1..2^SCORE_W-1.
REQ-005 Parameter HOLD_SHORT, default 3000000, SHALL set the round hold in cycles when the lead is below 2.
REQ-006 Parameter HOLD_LONG, default 5000000, SHALL set the round hold in cycles when the lead is 2 or more.
REQ-007 Parameter LEAD_MARGIN, default 3, SHALL set the lead that ends a game when SCORE_LEAD_WIN_EN is defined.
REQ-008 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-009 rst  input  1  asynchronous, active-low reset.
REQ-010 start  input  N_PLAYERS  per-player roll button, asynchronous level.
REQ-011 dice  input  N_PLAYERS*DICE_W  packed die values, player p at bits [p*DICE_W +: DICE_W].
REQ-012 score  output  N_PLAYERS*SCORE_W  packed displayed scores, same packing as dice.
REQ-013 busy  output  1  high while a round hold or final hold is counting.
REQ-014 finish  output  1  one-cycle pulse on the last cycle of every hold.
REQ-015 game_over  output  1  high from game end until the final hold expires.
REQ-016 winner  output  2  index of the game winner, valid while game_over is high.

Function
REQ-017 Each start bit SHALL pass through a 2-flop synchroniser, then a falling-edge detector on the synchronised signal.
REQ-018 A detected falling edge SHALL set that player's armed flag; edges received while busy SHALL be ignored.
REQ-019 The FSM SHALL have states IDLE, EVAL, HOLD, FINAL.
REQ-020 IDLE->EVAL SHALL occur in the cycle after all armed flags are set; all armed flags SHALL clear on entry to EVAL.
REQ-021 EVAL SHALL last one cycle: the single strict maximum die SHALL add 1 to that player's internal score; a tie for the maximum SHALL add nothing.
REQ-022 Internal score increments SHALL saturate at 2^SCORE_W-1.
REQ-023 Lead SHALL be computed as (highest internal score) - (second highest) after the EVAL update.
REQ-024 EVAL->FINAL SHALL occur when any internal score reaches WIN_SCORE; game_over and winner SHALL be set in the same transition.
REQ-025 Otherwise EVAL->HOLD; the hold length SHALL be HOLD_SHORT if lead<2, else HOLD_LONG.
REQ-026 busy SHALL be high for exactly the hold length in cycles in HOLD and FINAL, starting the cycle after EVAL.
REQ-027 finish SHALL pulse in the last busy cycle; next state SHALL be IDLE.
REQ-028 The score output SHALL copy the internal scores in the cycle finish is high; it SHALL NOT change at any other time.
REQ-029 FINAL SHALL use HOLD_LONG; on expiry internal scores, score output, game_over and winner SHALL clear to 0.
REQ-030 Dice SHALL be sampled only in EVAL; changes at any other time SHALL have no effect.

Reset
REQ-031 rst low SHALL force FSM to IDLE and score, busy, finish, game_over, winner, counters, armed flags and synchroniser flops to 0, immediately and independent of clk.
REQ-032 Reset asserted mid-hold SHALL abort the round without updating score.
REQ-033 The first rising clk after rst deasserts SHALL NOT register a start edge.

Configuration
REQ-034 With SCORE_LEAD_WIN_EN defined, EVAL->FINAL SHALL also occur when lead >= LEAD_MARGIN, with winner set to the leader.
REQ-035 Without SCORE_LEAD_WIN_EN, only WIN_SCORE SHALL end a game, and LEAD_MARGIN SHALL be unused.

Verification (N_PLAYERS=2, HOLD_SHORT=10, HOLD_LONG=20, WIN_SCORE=3)
REQ-036 Release start0 then start1, dice=(5,2) -> busy 10 cycles, finish pulse on cycle 10, score=(1,0) at that cycle.
REQ-037 Equal dice (4,4) -> 10-cycle hold, score unchanged.
REQ-038 Three rounds won by p1 -> third round enters FINAL, game_over=1, winner=1, score=(0,3) shown, cleared to 0 after 20 cycles.
REQ-039 Lead reaches 2 -> next hold lasts 20 cycles; start toggled during the hold -> no extra round.
REQ-040 rst pulsed low at hold cycle 5 -> all outputs 0 at once, FSM in IDLE, score unchanged from 0.
REQ-041 With SCORE_LEAD_WIN_EN and LEAD_MARGIN=2: scores reach (2,0) -> game_over=1, winner=0.

Source files
------------

// File: rtl/multi_score.sv
// multi_score: multi-player dice scoring with round/final hold timers.
// Optional SCORE_LEAD_WIN_EN also ends a game once the lead reaches LEAD_MARGIN.
module multi_score #(
    parameter int N_PLAYERS   = 2,
    parameter int DICE_W      = 4,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 5,
    parameter int HOLD_SHORT  = 3000000,
    parameter int HOLD_LONG   = 5000000,
    parameter int LEAD_MARGIN = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PLAYERS-1:0]          start,
    input  logic [N_PLAYERS*DICE_W-1:0]   dice,
    output logic [N_PLAYERS*SCORE_W-1:0]  score,
    output logic                          busy,
    output logic                          finish,
    output logic                          game_over,
    output logic [1:0]                    winner
);
    localparam int CW = $clog2(HOLD_LONG + 1);
    typedef enum logic [1:0] {IDLE, EVAL, HOLD, FINAL} state_t;
    state_t                       r_state, w_next;
    logic [N_PLAYERS-1:0]         r_s1, r_s2, r_s3, r_armed;
    logic [CW-1:0]                r_cnt;
    logic [N_PLAYERS*SCORE_W-1:0] r_int, r_disp, w_new;
    logic [SCORE_W-1:0]           w_mx, w_sd;
    logic [DICE_W-1:0]            w_dmx;
    logic [1:0]                   w_didx, w_lidx;
    logic                         w_tie, w_end;

    assign busy   = (r_state == HOLD) || (r_state == FINAL);
    assign finish = busy && (r_cnt == '0);
    // the fresh internal score is visible during the finish cycle itself
    assign score  = finish ? r_int : r_disp;

    always_comb begin
        w_dmx  = dice[0 +: DICE_W];
        w_didx = 2'd0;
        w_tie  = 1'b0;
        for (int p = 1; p < N_PLAYERS; p++)
            if (dice[p*DICE_W +: DICE_W] > w_dmx) begin
                w_dmx  = dice[p*DICE_W +: DICE_W];
                w_didx = 2'(p);
                w_tie  = 1'b0;
            end else if (dice[p*DICE_W +: DICE_W] == w_dmx)
                w_tie = 1'b1;
        w_new = r_int;
        for (int p = 0; p < N_PLAYERS; p++)
            if (!w_tie && w_didx == 2'(p) && r_int[p*SCORE_W +: SCORE_W] != '1)
                w_new[p*SCORE_W +: SCORE_W] = r_int[p*SCORE_W +: SCORE_W] + SCORE_W'(1);
        // a score equal to the running max drops into second place, so ties give lead 0
        w_mx   = w_new[0 +: SCORE_W];
        w_sd   = '0;
        w_lidx = 2'd0;
        for (int p = 1; p < N_PLAYERS; p++)
            if (w_new[p*SCORE_W +: SCORE_W] > w_mx) begin
                w_sd   = w_mx;
                w_mx   = w_new[p*SCORE_W +: SCORE_W];
                w_lidx = 2'(p);
            end else if (w_new[p*SCORE_W +: SCORE_W] > w_sd)
                w_sd = w_new[p*SCORE_W +: SCORE_W];
`ifdef SCORE_LEAD_WIN_EN
        w_end = (w_mx >= SCORE_W'(WIN_SCORE)) || ((w_mx - w_sd) >= SCORE_W'(LEAD_MARGIN));
`else
        w_end = w_mx >= SCORE_W'(WIN_SCORE);
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = &r_armed ? EVAL : IDLE;
            EVAL:    w_next = w_end ? FINAL : HOLD;
            default: w_next = finish ? IDLE : r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_armed   <= '0;
            r_cnt     <= '0;
            r_int     <= '0;
            r_disp    <= '0;
            game_over <= 1'b0;
            winner    <= 2'd0;
        end else begin
            r_s1    <= start;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_armed <= (r_state == IDLE && &r_armed) ? '0 :
                       busy ? r_armed : r_armed | (r_s3 & ~r_s2);
            if (r_state == EVAL) begin
                r_int     <= w_new;
                r_cnt     <= (w_end || (w_mx - w_sd) >= SCORE_W'(2)) ? CW'(HOLD_LONG - 1) : CW'(HOLD_SHORT - 1);
                game_over <= w_end;
                winner    <= w_end ? w_lidx : 2'd0;
            end else if (busy)
                r_cnt <= r_cnt - CW'(1);
            if (finish) begin
                r_disp <= (r_state == FINAL) ? '0 : r_int;
                if (r_state == FINAL) begin
                    r_int     <= '0;
                    game_over <= 1'b0;
                    winner    <= 2'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_score.sv
// tb_multi_score: table rounds, reset abort and random rounds against a score model.
module tb_multi_score;
    localparam int LM = 2;
    logic       clk = 1'b0, rst = 1'b0;
    logic [1:0] start = 2'b00;
    logic [7:0] dice = 8'h00;
    logic [7:0] score;
    logic       busy, finish, game_over;
    logic [1:0] winner;
    int n_tests = 0, n_fail = 0, disp = 0;
    int ms[2];

    typedef struct {int d0, d1, len, s0, s1, go, win;} vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    multi_score #(.N_PLAYERS(2), .DICE_W(4), .SCORE_W(4), .WIN_SCORE(3),
                  .HOLD_SHORT(10), .HOLD_LONG(20), .LEAD_MARGIN(LM)) dut (
        .clk(clk), .rst(rst), .start(start), .dice(dice), .score(score),
        .busy(busy), .finish(finish), .game_over(game_over), .winner(winner));

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_round(input int d0, input int d1,
                               output int len, output int s0, output int s1, output int go, output int win);
        int hi, lead;
        if (d0 > d1) ms[0] = (ms[0] < 15) ? ms[0] + 1 : 15;
        else if (d1 > d0) ms[1] = (ms[1] < 15) ? ms[1] + 1 : 15;
        s0   = ms[0];
        s1   = ms[1];
        hi   = (s0 > s1) ? s0 : s1;
        lead = (s0 > s1) ? s0 - s1 : s1 - s0;
        go   = (hi >= 3) ? 1 : 0;
`ifdef SCORE_LEAD_WIN_EN
        if (lead >= LM) go = 1;
`endif
        win = (s1 > s0) ? 1 : 0;
        len = (go != 0 || lead >= 2) ? 20 : 10;
        if (go != 0) begin
            ms[0] = 0;
            ms[1] = 0;
        end
    endtask

    task automatic run_round(input int d0, input int d1, input int len, input int s0, input int s1,
                             input int go, input int win, input int gap);
        int n, nf, fc, fs, bad, w;
        dice  = 8'(d1 * 16 + d0);
        start = 2'b11;
        repeat (3) @(negedge clk);
        start[0] = 1'b0;
        repeat (gap) @(negedge clk);
        start[1] = 1'b0;
        w = 0;
        while (!busy && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("busy_start", int'(busy), 1);
        if (!busy) return;
        n = 0; nf = 0; fc = 0; fs = -1; bad = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 1) begin
                chk("game_over", int'(game_over), go);
                if (go != 0) chk("winner", int'(winner), win);
            end
            if (finish) begin
                nf++;
                fc = n;
                fs = int'(score);
            end else if (int'(score) != disp) bad++;
            dice  = 8'($urandom);
            start = (n >= 2 && n <= 5) ? 2'($urandom) : 2'b00;
            @(negedge clk);
        end
        chk("hold_len", n, len);
        chk("finish_cycle", fc, len);
        chk("finish_count", nf, 1);
        chk("shown_score", fs, s1 * 16 + s0);
        chk("score_stable", bad, 0);
        disp = (go != 0) ? 0 : s1 * 16 + s0;
        chk("post_score", int'(score), disp);
        chk("post_game_over", int'(game_over), 0);
        w = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy) w++;
        end
        chk("no_extra_round", w, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len, s0, s1, go, win, d0, d1, w;
        tbl.push_back('{5, 2, 10, 1, 0, 0, 0});
        tbl.push_back('{4, 4, 10, 1, 0, 0, 0});
        tbl.push_back('{1, 6, 10, 1, 1, 0, 0});
        tbl.push_back('{2, 9, 10, 1, 2, 0, 0});
        tbl.push_back('{0, 15, 20, 1, 3, 1, 1});
        tbl.push_back('{3, 7, 10, 0, 1, 0, 0});
`ifdef SCORE_LEAD_WIN_EN
        tbl.push_back('{3, 7, 20, 0, 2, 1, 1});
        tbl.push_back('{9, 1, 10, 1, 0, 0, 0});
        tbl.push_back('{9, 1, 20, 2, 0, 1, 0});
`else
        tbl.push_back('{3, 7, 20, 0, 2, 0, 0});
        tbl.push_back('{3, 7, 20, 0, 3, 1, 1});
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_finish", int'(finish), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_winner", int'(winner), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        foreach (tbl[i])
            run_round(tbl[i].d0, tbl[i].d1, tbl[i].len, tbl[i].s0, tbl[i].s1, tbl[i].go, tbl[i].win, i % 3);

        dice  = 8'h25;
        start = 2'b11;
        repeat (3) @(negedge clk);
        start = 2'b00;
        w = 0;
        while (!busy && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("abort_busy_start", int'(busy), 1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_finish", int'(finish), 0);
        chk("abort_score", int'(score), 0);
        chk("abort_game_over", int'(game_over), 0);
        chk("abort_winner", int'(winner), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        w = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) w++;
        end
        chk("abort_idle", w, 0);
        disp  = 0;
        ms[0] = 0;
        ms[1] = 0;
        model_round(5, 2, len, s0, s1, go, win);
        run_round(5, 2, len, s0, s1, go, win, 1);

        for (int r = 0; r < 30; r++) begin
            d0 = int'($urandom_range(0, 15));
            d1 = ($urandom_range(0, 3) == 0) ? d0 : int'($urandom_range(0, 15));
            model_round(d0, d1, len, s0, s1, go, win);
            run_round(d0, d1, len, s0, s1, go, win, int'($urandom_range(0, 3)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
